// File: rtl/axi_addr_burst_gen.sv
// AXI AR/AW address-channel burst generator: splits a beat count into boundary-safe
// INCR / WRAP / STRIDE bursts with rotating IDs and an outstanding-burst credit limit.
module axi_addr_burst_gen #(
    parameter int ADDR_W          = 64,
    parameter int CNT_W           = 40,
    parameter int ID_W            = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int BOUNDARY_LOG2   = 12
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] axi_addr,
    output logic [7:0]        axi_len,
    output logic [2:0]        axi_size,
    output logic [ID_W-1:0]   axi_id,
    output logic              axi_valid,
    input  logic              axi_ready,
    input  logic              burst_cmpl,
    input  logic              engine_start,
    input  logic [1:0]        mode,
    input  logic [3:0]        wrap_len,
    input  logic [31:0]       stride,
    input  logic [ADDR_W-1:0] source_address,
    input  logic [CNT_W-1:0]  total_beat_count,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic              abort,
    output logic              busy,
    output logic              addr_send_done,
    output logic [31:0]       bursts_issued,
    output logic [7:0]        outstanding
);
    typedef enum logic [2:0] {IDLE, INIT, CALC, SEND, DRAIN, DONE} state_t;
    localparam int BW = BOUNDARY_LOG2 + 1;

    state_t              state;
    logic [1:0]          cfg_mode;
    logic [3:0]          cfg_wrap_len;
    logic [31:0]         cfg_stride;
    logic [ADDR_W-1:0]   cfg_src;
    logic [7:0]          cfg_len;
    logic [CNT_W-1:0]    remain;
    logic [ADDR_W-1:0]   elem_start;
    logic [8:0]          elem_left;
    logic [8:0]          burst_beats;
    logic                abort_seen;

    logic                handshake;
    logic                cmpl_eff;
    logic [BOUNDARY_LOG2-1:0] low_addr;
    logic [BW-1:0]       to_boundary;
    logic [8:0]          limit;
    logic [8:0]          calc_beats;
    logic [8:0]          elem_left_nx;
    logic [ADDR_W-1:0]   incr_addr;
    logic [ADDR_W-1:0]   win_mask;
    logic [ADDR_W-1:0]   next_addr;

    assign handshake = axi_valid && axi_ready;
    assign cmpl_eff  = burst_cmpl && (outstanding != 8'd0);
    assign busy      = (state != IDLE);

    // In STRIDE mode a burst is limited by what is left of the current stride element,
    // so a boundary split continues the same element instead of jumping ahead.
    always_comb begin
        low_addr    = axi_addr[BOUNDARY_LOG2-1:0];
        to_boundary = (BW'(1) << (BOUNDARY_LOG2 - int'(axi_size))) - BW'(low_addr >> axi_size);
        limit       = (cfg_mode == 2'd2) ? elem_left : ({1'b0, cfg_len} + 9'd1);
        calc_beats  = limit;
        if (16'(to_boundary) < 16'(calc_beats))
            calc_beats = 9'(to_boundary);
        if (remain < CNT_W'(calc_beats))
            calc_beats = 9'(remain);

        incr_addr    = axi_addr + (ADDR_W'(burst_beats) << axi_size);
        win_mask     = (ADDR_W'(1) << (12 + int'(cfg_wrap_len))) - ADDR_W'(1);
        elem_left_nx = elem_left - burst_beats;
        case (cfg_mode)
            2'd1:    next_addr = (incr_addr & win_mask) | (cfg_src & ~win_mask);
            2'd2:    next_addr = (elem_left_nx != 9'd0) ? incr_addr
                                                        : elem_start + ADDR_W'(cfg_stride);
            default: next_addr = incr_addr;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cfg_mode       <= '0;
            cfg_wrap_len   <= '0;
            cfg_stride     <= '0;
            cfg_src        <= '0;
            cfg_len        <= '0;
            remain         <= '0;
            elem_start     <= '0;
            elem_left      <= '0;
            burst_beats    <= '0;
            abort_seen     <= 1'b0;
            axi_addr       <= '0;
            axi_len        <= '0;
            axi_size       <= '0;
            axi_id         <= '0;
            axi_valid      <= 1'b0;
            addr_send_done <= 1'b0;
            bursts_issued  <= '0;
            outstanding    <= '0;
        end else begin
            addr_send_done <= 1'b0;
            if (handshake && !cmpl_eff)
                outstanding <= outstanding + 8'd1;
            else if (!handshake && cmpl_eff)
                outstanding <= outstanding - 8'd1;

            case (state)
                IDLE: begin
                    if (engine_start)
                        state <= INIT;
                end
                INIT: begin
                    cfg_mode      <= (mode == 2'd3) ? 2'd0 : mode;
                    cfg_wrap_len  <= wrap_len;
                    cfg_stride    <= stride;
                    cfg_src       <= source_address;
                    cfg_len       <= len;
                    axi_size      <= (size < 3'd2) ? 3'd7 : size;
                    axi_addr      <= source_address;
                    elem_start    <= source_address;
                    remain        <= total_beat_count;
                    elem_left     <= {1'b0, len} + 9'd1;
                    bursts_issued <= '0;
                    axi_id        <= '0;
                    abort_seen    <= 1'b0;
                    state         <= abort ? DRAIN : CALC;
                end
                CALC: begin
                    if (abort || remain == '0) begin
                        state <= DRAIN;
                    end else if (outstanding < 8'(MAX_OUTSTANDING)) begin
                        burst_beats <= calc_beats;
                        axi_len     <= 8'(calc_beats - 9'd1);
                        axi_valid   <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (abort)
                        abort_seen <= 1'b1;
                    if (axi_ready) begin
                        axi_valid     <= 1'b0;
                        axi_addr      <= next_addr;
                        remain        <= remain - CNT_W'(burst_beats);
                        bursts_issued <= bursts_issued + 32'd1;
                        axi_id        <= axi_id + 1'b1;
                        if (cfg_mode == 2'd2) begin
                            if (elem_left_nx == 9'd0) begin
                                elem_start <= next_addr;
                                elem_left  <= {1'b0, cfg_len} + 9'd1;
                            end else begin
                                elem_left  <= elem_left_nx;
                            end
                        end
                        state <= (abort || abort_seen) ? DRAIN : CALC;
                    end
                end
                DRAIN: begin
                    if (outstanding == 8'd0) begin
                        addr_send_done <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_axi_addr_burst_gen.sv
// Self-checking bench for axi_addr_burst_gen: directed scenarios plus randomized jobs
// checked against a burst-list reference model computed with plain byte arithmetic.
module tb_axi_addr_burst_gen;
    localparam int ADDR_W   = 64;
    localparam int CNT_W    = 40;
    localparam int ID_W     = 4;
    localparam int MAX_OUT  = 2;
    localparam longint unsigned BOUNDARY = 4096;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] axi_addr;
    logic [7:0]        axi_len;
    logic [2:0]        axi_size;
    logic [ID_W-1:0]   axi_id;
    logic              axi_valid;
    logic              axi_ready;
    logic              burst_cmpl;
    logic              engine_start;
    logic [1:0]        mode;
    logic [3:0]        wrap_len;
    logic [31:0]       stride;
    logic [ADDR_W-1:0] source_address;
    logic [CNT_W-1:0]  total_beat_count;
    logic [2:0]        size;
    logic [7:0]        len;
    logic              abort;
    logic              busy;
    logic              addr_send_done;
    logic [31:0]       bursts_issued;
    logic [7:0]        outstanding;

    always #5 clk = ~clk;

    axi_addr_burst_gen #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ID_W(ID_W),
        .MAX_OUTSTANDING(MAX_OUT), .BOUNDARY_LOG2(12)
    ) dut (
        .clk(clk), .reset(reset),
        .axi_addr(axi_addr), .axi_len(axi_len), .axi_size(axi_size), .axi_id(axi_id),
        .axi_valid(axi_valid), .axi_ready(axi_ready), .burst_cmpl(burst_cmpl),
        .engine_start(engine_start), .mode(mode), .wrap_len(wrap_len), .stride(stride),
        .source_address(source_address), .total_beat_count(total_beat_count),
        .size(size), .len(len), .abort(abort), .busy(busy),
        .addr_send_done(addr_send_done), .bursts_issued(bursts_issued),
        .outstanding(outstanding)
    );

    int checks = 0;
    int errors = 0;
    int model_out = 0;
    longint unsigned exp_addr[$];
    int exp_len[$];
    int exp_id[$];
    int exp_size;
    longint unsigned seen_addr[$];
    int seen_len[$];
    int seen_id[$];

    task automatic check_output(input string tag, input longint unsigned got, input longint unsigned expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Reference: walk the job in bytes and list every burst it must produce.
    task automatic build_model(input int m, input int wl, input longint unsigned st,
                               input longint unsigned src, input longint unsigned tot,
                               input int sz_raw, input int ln);
        longint unsigned addr, rem, estart, win, beat_bytes, to_bnd, lim, beats;
        int eleft;
        int id;
        exp_addr.delete(); exp_len.delete(); exp_id.delete();
        exp_size   = (sz_raw < 2) ? 7 : sz_raw;
        beat_bytes = longint'(1) << exp_size;
        win        = longint'(1) << (12 + wl);
        addr = src; estart = src; rem = tot; eleft = ln + 1; id = 0;
        while (rem > 0) begin
            to_bnd = (BOUNDARY - (addr % BOUNDARY)) / beat_bytes;
            lim    = (m == 2) ? longint'(eleft) : longint'(ln + 1);
            beats  = lim;
            if (to_bnd < beats) beats = to_bnd;
            if (rem < beats) beats = rem;
            exp_addr.push_back(addr);
            exp_len.push_back(int'(beats) - 1);
            exp_id.push_back(id % 16);
            rem = rem - beats;
            id++;
            if (m == 1) begin
                addr = ((addr + beats * beat_bytes) % win) + (src - (src % win));
            end else if (m == 2) begin
                eleft = eleft - int'(beats);
                if (eleft > 0) begin
                    addr = addr + beats * beat_bytes;
                end else begin
                    estart = estart + st;
                    addr   = estart;
                    eleft  = ln + 1;
                end
            end else begin
                addr = addr + beats * beat_bytes;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        axi_ready = 1'b0; burst_cmpl = 1'b0; engine_start = 1'b0; abort = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_out = 0;
    endtask

    task automatic drive_config(input int m, input int wl, input longint unsigned st,
                                input longint unsigned src, input longint unsigned tot,
                                input int sz, input int ln);
        mode = 2'(m); wrap_len = 4'(wl); stride = 32'(st);
        source_address = src; total_beat_count = CNT_W'(tot);
        size = 3'(sz); len = 8'(ln);
    endtask

    // Runs one job with random ready/cmpl and scrambled config after INIT.
    task automatic apply_stimulus(input int m, input int wl, input longint unsigned st,
                                  input longint unsigned src, input longint unsigned tot,
                                  input int sz, input int ln, input int rdy_pct,
                                  input int cmp_pct, input bit garble);
        int idx, first_valid, done_cyc;
        bit rdy, cmp;
        build_model(m, wl, st, src, tot, sz, ln);
        seen_addr.delete(); seen_len.delete(); seen_id.delete();
        @(negedge clk);
        drive_config(m, wl, st, src, tot, sz, ln);
        abort = 1'b0; engine_start = 1'b1;
        idx = 0; first_valid = -1; done_cyc = -1;
        for (int cyc = 1; cyc <= 5000; cyc++) begin
            @(negedge clk);
            engine_start = 1'b0;
            if (garble && cyc >= 2) begin
                mode = 2'($urandom); wrap_len = 4'($urandom); stride = $urandom;
                source_address = {$urandom, $urandom}; total_beat_count = CNT_W'($urandom);
                size = 3'($urandom); len = 8'($urandom); engine_start = 1'($urandom);
            end
            check_output("outstanding", outstanding, longint'(model_out));
            if (axi_valid && first_valid < 0) first_valid = cyc;
            if (addr_send_done) begin
                done_cyc = cyc;
                engine_start = 1'b0;
                break;
            end
            rdy = ($urandom_range(0, 99) < rdy_pct);
            cmp = (model_out > 0) && ($urandom_range(0, 99) < cmp_pct);
            axi_ready = rdy; burst_cmpl = cmp;
            if (axi_valid && rdy) begin
                check_output("credit", longint'(outstanding < MAX_OUT), 1);
                if (idx < exp_addr.size()) begin
                    check_output("burst_addr", axi_addr, exp_addr[idx]);
                    check_output("burst_len", axi_len, longint'(exp_len[idx]));
                    check_output("burst_id", axi_id, longint'(exp_id[idx]));
                    check_output("burst_size", axi_size, longint'(exp_size));
                end else begin
                    check_output("extra_burst", longint'(idx), longint'(exp_addr.size()));
                end
                seen_addr.push_back(axi_addr);
                seen_len.push_back(int'(axi_len));
                seen_id.push_back(int'(axi_id));
                idx++;
                model_out++;
            end
            if (cmp) model_out--;
        end
        axi_ready = 1'b0; burst_cmpl = 1'b0; engine_start = 1'b0;
        check_output("done_seen", longint'(done_cyc > 0), 1);
        check_output("burst_count", longint'(idx), longint'(exp_addr.size()));
        check_output("bursts_issued", bursts_issued, longint'(exp_addr.size()));
        if (exp_addr.size() > 0) begin
            check_output("first_valid_latency", longint'(first_valid), 3);
        end else begin
            check_output("zero_job_no_valid", longint'(first_valid < 0), 1);
            check_output("zero_job_done_cycle", longint'(done_cyc), 4);
        end
        if (done_cyc < 0) do_reset();
    endtask

    // Always-ready, always-complete drain of whatever the DUT still has to do.
    task automatic finish_job(input int budget, output int hs, output int done_cyc);
        hs = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clk);
            engine_start = 1'b0;
            if (addr_send_done) begin
                done_cyc = cyc;
                break;
            end
            axi_ready  = 1'b1;
            burst_cmpl = (model_out > 0);
            if (axi_valid) begin
                hs++;
                model_out++;
            end
            if (burst_cmpl) model_out--;
        end
        axi_ready = 1'b0; burst_cmpl = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hs, hs2, done_cyc, got_valid;
        longint unsigned src, st;
        int m, wl, sz, esz, ln, tot;

        reset = 1'b1;
        axi_ready = 1'b0; burst_cmpl = 1'b0; engine_start = 1'b0; abort = 1'b0;
        drive_config(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_output("reset_valid", axi_valid, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_outstanding", outstanding, 0);
        check_output("reset_bursts", bursts_issued, 0);
        check_output("reset_done", addr_send_done, 0);
        check_output("reset_addr", axi_addr, 0);
        check_output("reset_id", axi_id, 0);
        check_output("reset_len", axi_len, 0);
        reset = 1'b0;

        // burst_cmpl with nothing in flight must not underflow
        @(negedge clk);
        burst_cmpl = 1'b1;
        @(negedge clk);
        burst_cmpl = 1'b0;
        check_output("cmpl_at_zero", outstanding, 0);

        apply_stimulus(0, 0, 0, 64'h1F80, 40, 5, 15, 100, 100, 1'b1);
        check_output("incr_n", seen_addr.size(), 4);
        check_output("incr_a0", seen_addr[0], 64'h1F80);
        check_output("incr_a1", seen_addr[1], 64'h2000);
        check_output("incr_a2", seen_addr[2], 64'h2200);
        check_output("incr_a3", seen_addr[3], 64'h2400);
        check_output("incr_l0", seen_len[0], 3);
        check_output("incr_l1", seen_len[1], 15);
        check_output("incr_l2", seen_len[2], 15);
        check_output("incr_l3", seen_len[3], 3);

        apply_stimulus(1, 0, 0, 64'h10000, 128, 6, 63, 100, 100, 1'b1);
        check_output("wrap_n", seen_addr.size(), 2);
        check_output("wrap_a0", seen_addr[0], 64'h10000);
        check_output("wrap_a1", seen_addr[1], 64'h10000);
        check_output("wrap_id0", seen_id[0], 0);
        check_output("wrap_id1", seen_id[1], 1);

        apply_stimulus(2, 0, 64'h2000, 64'h0, 24, 7, 7, 100, 100, 1'b1);
        check_output("stride_n", seen_addr.size(), 3);
        check_output("stride_a0", seen_addr[0], 64'h0);
        check_output("stride_a1", seen_addr[1], 64'h2000);
        check_output("stride_a2", seen_addr[2], 64'h4000);
        for (int i = 0; i < 3; i++) check_output("stride_len", seen_len[i], 7);

        apply_stimulus(0, 0, 0, 64'h100, 0, 3, 7, 100, 100, 1'b1);

        // credit limit: no completions -> exactly MAX_OUT bursts, then one more per cmpl
        do_reset();
        @(negedge clk);
        drive_config(0, 0, 0, 0, 5, 2, 0);
        engine_start = 1'b1; axi_ready = 1'b1; burst_cmpl = 1'b0;
        hs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            engine_start = 1'b0;
            if (axi_valid) begin hs++; model_out++; end
        end
        check_output("credit_hs", hs, 2);
        check_output("credit_outstanding", outstanding, 2);
        check_output("credit_valid_low", axi_valid, 0);
        burst_cmpl = 1'b1;
        model_out--;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            burst_cmpl = 1'b0;
            if (axi_valid) begin hs++; model_out++; end
        end
        check_output("credit_hs_after_cmpl", hs, 3);
        check_output("credit_outstanding2", outstanding, 2);
        finish_job(200, hs2, done_cyc);
        check_output("credit_rest_hs", hs2, 2);
        check_output("credit_done", longint'(done_cyc > 0), 1);
        check_output("credit_bursts", bursts_issued, 5);

        // abort while SEND is stalled: burst completes, nothing more issues
        do_reset();
        @(negedge clk);
        drive_config(0, 0, 0, 0, 100, 2, 3);
        engine_start = 1'b1; axi_ready = 1'b0;
        got_valid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            engine_start = 1'b0;
            if (axi_valid) begin got_valid = 1; break; end
        end
        check_output("abort_valid_seen", got_valid, 1);
        abort = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("abort_hold_valid", axi_valid, 1);
            check_output("abort_hold_addr", axi_addr, 0);
            if (k == 1) abort = 1'b0;
        end
        axi_ready = 1'b1;
        model_out++;
        finish_job(200, hs, done_cyc);
        check_output("abort_no_more_bursts", hs, 0);
        check_output("abort_done", longint'(done_cyc > 0), 1);
        check_output("abort_bursts", bursts_issued, 1);

        // abort held from the start: no bursts at all
        @(negedge clk);
        drive_config(0, 0, 0, 0, 50, 2, 3);
        abort = 1'b1; engine_start = 1'b1;
        finish_job(50, hs, done_cyc);
        abort = 1'b0;
        check_output("abort_init_hs", hs, 0);
        check_output("abort_init_done", longint'(done_cyc), 3);
        check_output("abort_init_bursts", bursts_issued, 0);

        // reset in the middle of a job
        @(negedge clk);
        drive_config(0, 0, 0, 0, 50, 2, 3);
        engine_start = 1'b1; axi_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            engine_start = 1'b0;
            if (axi_valid) break;
        end
        reset = 1'b1;
        #1;
        check_output("midreset_valid", axi_valid, 0);
        check_output("midreset_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        model_out = 0;

        for (int j = 0; j < 30; j++) begin
            m   = $urandom_range(0, 3);
            wl  = $urandom_range(0, 15);
            sz  = $urandom_range(0, 7);
            esz = (sz < 2) ? 7 : sz;
            ln  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            tot = $urandom_range(0, 200);
            src = {$urandom, $urandom} & ~((longint'(1) << esz) - 1);
            st  = longint'($urandom_range(0, 65535)) & ~((longint'(1) << esz) - 1);
            apply_stimulus(m, wl, st, src, tot, sz, ln,
                           $urandom_range(30, 100), $urandom_range(20, 100), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
